sfx_engine: RTL and testbench
=============================

Name: sfx_engine

Overview:
- Multi-channel sound-effect generator for game events (jump, death, score and similar).
- Each voice plays a square-wave frequency sweep of programmable start period, step, direction, length and volume when triggered.
- Voices are summed, saturated and converted to a 1-bit PWM stream for the board audio jack, with an amplifier-enable output.
- Sits between the game-logic FSM (trigger pulses) and the top-level audio pins.

Parameters:
- NUM_CH, 2, number of independent voices.
- PER_W, 24, width of half-period counter and period register (clock cycles).
- LEN_W, 12, width of effect length, counted in half-cycles.
- STEP_W, 16, width of per-half-cycle period step.
- VOL_W, 4, per-voice volume width.
- PWM_W, 8, PWM DAC resolution.
- MIN_PER, 16, period floor applied during downward sweeps; also the value substituted for a zero start period.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- CPU_RESETN  in  1  asynchronous, active-low reset.
- trigger  in  NUM_CH  per-voice start; rising edge detected internally.
- start_per  in  NUM_CH*PER_W  packed initial half-period per voice.
- step  in  NUM_CH*STEP_W  packed period delta applied at each toggle.
- sweep_up  in  NUM_CH  1 = period grows (pitch falls); 0 = period shrinks.
- length  in  NUM_CH*LEN_W  half-cycles to play; 0 = ignore trigger.
- volume  in  NUM_CH*VOL_W  amplitude of the high phase.
- mute  in  1  forces the PWM sample to 0; voices keep running.
- busy  out  NUM_CH  voice active.
- audio_out  out  1  PWM audio.
- amp_en  out  1  amplifier power enable.

Behaviour:
- Reset (async assert, sync release): all voices IDLE; phase, counters and period are 0; busy=0, audio_out=0, amp_en=0; PWM counter and latched sample are 0.
- Trigger edge detect: trig_q is registered. Start = trigger & ~trig_q.
- Start sampling: start_per, step, sweep_up, length and volume are captured on the start cycle. Later changes have no effect until the next start.
- Voice FSM states: IDLE and PLAY.
- IDLE -> PLAY on start with length != 0. Loads period=start_per (MIN_PER if 0), cnt=0, remain=length, phase=0. busy=1 from the next cycle.
- PLAY, each cycle with cnt < period-1: cnt++.
- PLAY, cycle with cnt == period-1: cnt<=0, phase<=~phase, remain<=remain-1, period updated as follows:
  - sweep_up=1: period+step, saturating at 2^PER_W-1.
  - sweep_up=0: period-step, clamped to MIN_PER.
- End of effect: if remain==1 at a toggle, go PLAY -> IDLE with phase<=0 and busy<=0.
- Timing: the first toggle occurs start_per cycles after busy rises.
- Retrigger while in PLAY restarts the voice from the fresh configuration. There is no glitch beyond phase forced to 0.
- Mixer: level = sum over voices of (phase ? volume : 0). Width is VOL_W + clog2(NUM_CH). Saturate to 2^PWM_W-1.
- PWM counter: free-running PWM_W-bit pwm_cnt.
- Sample latch: sample <= mute ? 0 : level when pwm_cnt == 2^PWM_W-1.
- PWM output: audio_out registered = (pwm_cnt < sample). sample=0 gives constant 0; full scale gives high for all but one count.
- amp_en registered = |busy | (sample != 0). amp_en drops one PWM frame after the last voice ends.
- Simultaneous starts on several voices are all honoured in the same cycle.
- Reset mid-effect returns to the reset state immediately.

Decomposition:
- Shared package sfx_pkg holds:
  - voice state enum {IDLE, PLAY};
  - width helper constants (sum width);
  - default MIN_PER.
- One sub-module, sfx_voice, contains the edge detect, FSM, period/sweep arithmetic and phase. sfx_engine instantiates NUM_CH voices plus the mixer and PWM.

Test Plan:
- Basic tone: voice0 start_per=4, step=0, length=4, volume=15. Expect phase toggles every 4 cycles, 4 toggles, then busy=0 exactly 16 cycles after busy rose.
- Sweep down: start_per=100, step=30, sweep_up=0, length=6. Expect half-periods 100,70,40,16,16,16 (clamped at MIN_PER).
- Retrigger: voice0 start_per=50, length=10, retriggered at cycle 30. Expect cnt reset, phase 0, full 10 half-cycles from the retrigger.
- Mixer saturation: PWM_W=4, two voices volume=15 both high. Expect sample=15 and audio_out high 15 of 16 counts; mute=1 gives sample 0 at the next frame.
- Length zero / idle: trigger with length=0. Expect busy stays 0 and amp_en stays 0.
- Reset mid-play: assert CPU_RESETN=0 during PLAY. Expect busy, audio_out and amp_en 0 immediately (asynchronously); no activity after release until a new edge.

Source files
------------

// File: rtl/sfx_pkg.sv
// Shared types and constants for the sound-effect engine.
// Imported by the voice sub-module and the engine top.
package sfx_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } voice_state_t;

   localparam int DEFAULT_MIN_PER = 16;

   // Mixer width that holds the sum of num_ch voices of vol_w bits without overflow.
   function automatic int sum_width(input int vol_w, input int num_ch);
      return vol_w + $clog2(num_ch);
   endfunction

endpackage

// File: rtl/sfx_voice.sv
// One sound-effect voice: trigger edge detect, IDLE/PLAY FSM and a square wave
// whose half-period sweeps up (saturating) or down (floored at MIN_PER) at each toggle.
module sfx_voice
   import sfx_pkg::*;
#(
   parameter int PER_W   = 24,
   parameter int LEN_W   = 12,
   parameter int STEP_W  = 16,
   parameter int VOL_W   = 4,
   parameter int MIN_PER = DEFAULT_MIN_PER
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trigger,
   input  logic [PER_W-1:0]  start_per,
   input  logic [STEP_W-1:0] step,
   input  logic              sweep_up,
   input  logic [LEN_W-1:0]  length,
   input  logic [VOL_W-1:0]  volume,
   output logic              busy,
   output logic              phase,
   output logic [VOL_W-1:0]  vol
);

   // Two spare bits so period+step and step+MIN_PER never wrap.
   localparam int AW = ((PER_W > STEP_W) ? PER_W : STEP_W) + 2;
   localparam logic [PER_W-1:0] MIN_P     = PER_W'(MIN_PER);
   localparam logic [AW-1:0]    PER_MAX_W = AW'({PER_W{1'b1}});

   voice_state_t      state_reg, state_next;
   logic              trig_q_reg;
   logic [PER_W-1:0]  cnt_reg, cnt_next;
   logic [PER_W-1:0]  period_reg, period_next;
   logic [LEN_W-1:0]  remain_reg, remain_next;
   logic              phase_reg, phase_next;
   logic [STEP_W-1:0] step_reg, step_next;
   logic              up_reg, up_next;
   logic [VOL_W-1:0]  vol_reg, vol_next;

   logic              start;
   logic [AW-1:0]     per_ext, step_ext, up_sum;
   logic [PER_W-1:0]  swept_per;

   assign start = trigger & ~trig_q_reg;

   always_comb begin
      per_ext  = AW'(period_reg);
      step_ext = AW'(step_reg);
      up_sum   = per_ext + step_ext;
      if (up_reg) begin
         swept_per = (up_sum > PER_MAX_W) ? PER_W'(PER_MAX_W) : PER_W'(up_sum);
      end else begin
         swept_per = (per_ext < step_ext + AW'(MIN_P)) ? MIN_P : PER_W'(per_ext - step_ext);
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      period_next = period_reg;
      remain_next = remain_reg;
      phase_next  = phase_reg;
      step_next   = step_reg;
      up_next     = up_reg;
      vol_next    = vol_reg;
      // A fresh start wins over everything, including the final toggle of a running effect.
      if (start && (length != '0)) begin
         state_next  = PLAY;
         cnt_next    = '0;
         period_next = (start_per == '0) ? MIN_P : start_per;
         remain_next = length;
         phase_next  = 1'b0;
         step_next   = step;
         up_next     = sweep_up;
         vol_next    = volume;
      end else if (state_reg == PLAY) begin
         if (cnt_reg == period_reg - PER_W'(1)) begin
            cnt_next    = '0;
            remain_next = remain_reg - LEN_W'(1);
            period_next = swept_per;
            if (remain_reg == LEN_W'(1)) begin
               state_next = IDLE;
               phase_next = 1'b0;
            end else begin
               phase_next = ~phase_reg;
            end
         end else begin
            cnt_next = cnt_reg + PER_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         trig_q_reg <= 1'b0;
         cnt_reg    <= '0;
         period_reg <= '0;
         remain_reg <= '0;
         phase_reg  <= 1'b0;
         step_reg   <= '0;
         up_reg     <= 1'b0;
         vol_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         trig_q_reg <= trigger;
         cnt_reg    <= cnt_next;
         period_reg <= period_next;
         remain_reg <= remain_next;
         phase_reg  <= phase_next;
         step_reg   <= step_next;
         up_reg     <= up_next;
         vol_reg    <= vol_next;
      end
   end

   assign busy  = (state_reg == PLAY);
   assign phase = phase_reg;
   assign vol   = vol_reg;

endmodule

// File: rtl/sfx_engine.sv
// Multi-voice sound-effect generator: NUM_CH sweeping square-wave voices,
// a saturating mixer and a 1-bit PWM DAC with amplifier enable.
module sfx_engine
   import sfx_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int PER_W   = 24,
   parameter int LEN_W   = 12,
   parameter int STEP_W  = 16,
   parameter int VOL_W   = 4,
   parameter int PWM_W   = 8,
   parameter int MIN_PER = DEFAULT_MIN_PER
) (
   input  logic                     CLK100MHZ,
   input  logic                     CPU_RESETN,
   input  logic [NUM_CH-1:0]        trigger,
   input  logic [NUM_CH*PER_W-1:0]  start_per,
   input  logic [NUM_CH*STEP_W-1:0] step,
   input  logic [NUM_CH-1:0]        sweep_up,
   input  logic [NUM_CH*LEN_W-1:0]  length,
   input  logic [NUM_CH*VOL_W-1:0]  volume,
   input  logic                     mute,
   output logic [NUM_CH-1:0]        busy,
   output logic                     audio_out,
   output logic                     amp_en
);

   localparam int SUM_W = sum_width(VOL_W, NUM_CH);
   localparam int CMP_W = (SUM_W > PWM_W) ? SUM_W : PWM_W;
   localparam logic [CMP_W-1:0] PWM_MAX = CMP_W'((1 << PWM_W) - 1);
   localparam logic [PWM_W-1:0] PWM_TOP = '1;

   logic [NUM_CH-1:0] phase;
   logic [VOL_W-1:0]  voice_vol [NUM_CH];

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_voice
         sfx_voice #(
            .PER_W   (PER_W),
            .LEN_W   (LEN_W),
            .STEP_W  (STEP_W),
            .VOL_W   (VOL_W),
            .MIN_PER (MIN_PER)
         ) u_voice (
            .clk       (CLK100MHZ),
            .rst_n     (CPU_RESETN),
            .trigger   (trigger[gi]),
            .start_per (start_per[gi*PER_W +: PER_W]),
            .step      (step[gi*STEP_W +: STEP_W]),
            .sweep_up  (sweep_up[gi]),
            .length    (length[gi*LEN_W +: LEN_W]),
            .volume    (volume[gi*VOL_W +: VOL_W]),
            .busy      (busy[gi]),
            .phase     (phase[gi]),
            .vol       (voice_vol[gi])
         );
      end
   endgenerate

   logic [SUM_W-1:0] level_sum;
   logic [PWM_W-1:0] level_sat;

   always_comb begin
      level_sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (phase[i]) level_sum = level_sum + SUM_W'(voice_vol[i]);
      end
      level_sat = (CMP_W'(level_sum) > PWM_MAX) ? PWM_W'(PWM_MAX) : PWM_W'(level_sum);
   end

   logic [PWM_W-1:0] pwm_cnt_reg;
   logic [PWM_W-1:0] sample_reg;
   logic             audio_reg;
   logic             amp_reg;

   // Sample only changes at the frame wrap so every PWM frame has a single duty cycle.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         pwm_cnt_reg <= '0;
         sample_reg  <= '0;
         audio_reg   <= 1'b0;
         amp_reg     <= 1'b0;
      end else begin
         pwm_cnt_reg <= pwm_cnt_reg + PWM_W'(1);
         if (pwm_cnt_reg == PWM_TOP) sample_reg <= mute ? '0 : level_sat;
         audio_reg   <= (pwm_cnt_reg < sample_reg);
         amp_reg     <= (|busy) | (sample_reg != '0);
      end
   end

   assign audio_out = audio_reg;
   assign amp_en    = amp_reg;

endmodule

// File: tb/tb_sfx_engine.sv
// Self-checking bench for sfx_engine: directed scenarios plus random triggers,
// checked every cycle against a toggle-schedule reference model.
module tb_sfx_engine;

   localparam int NUM_CH  = 2;
   localparam int PER_W   = 10;
   localparam int LEN_W   = 12;
   localparam int STEP_W  = 16;
   localparam int VOL_W   = 4;
   localparam int PWM_W   = 4;
   localparam int MIN_PER = 16;
   localparam int PER_MAX = (1 << PER_W) - 1;
   localparam int PWM_MAX = (1 << PWM_W) - 1;
   localparam int FRAME   = 1 << PWM_W;
   localparam int MAX_TOG = 64;

   logic                     CLK100MHZ = 1'b0;
   logic                     CPU_RESETN;
   logic [NUM_CH-1:0]        trigger;
   logic [NUM_CH*PER_W-1:0]  start_per;
   logic [NUM_CH*STEP_W-1:0] step;
   logic [NUM_CH-1:0]        sweep_up;
   logic [NUM_CH*LEN_W-1:0]  length;
   logic [NUM_CH*VOL_W-1:0]  volume;
   logic                     mute;
   logic [NUM_CH-1:0]        busy;
   logic                     audio_out;
   logic                     amp_en;

   always #5 CLK100MHZ = ~CLK100MHZ;

   sfx_engine #(
      .NUM_CH  (NUM_CH),
      .PER_W   (PER_W),
      .LEN_W   (LEN_W),
      .STEP_W  (STEP_W),
      .VOL_W   (VOL_W),
      .PWM_W   (PWM_W),
      .MIN_PER (MIN_PER)
   ) dut (
      .CLK100MHZ  (CLK100MHZ),
      .CPU_RESETN (CPU_RESETN),
      .trigger    (trigger),
      .start_per  (start_per),
      .step       (step),
      .sweep_up   (sweep_up),
      .length     (length),
      .volume     (volume),
      .mute       (mute),
      .busy       (busy),
      .audio_out  (audio_out),
      .amp_en     (amp_en)
   );

   int total = 0;
   int bad   = 0;
   int n;

   // Reference model: each start precomputes the absolute edge of every toggle.
   bit m_trig_prev [NUM_CH];
   bit m_act       [NUM_CH];
   int m_start     [NUM_CH];
   int m_end       [NUM_CH];
   int m_vol       [NUM_CH];
   int m_ntog      [NUM_CH];
   int m_tog       [NUM_CH][MAX_TOG];
   bit exp_busy    [NUM_CH];
   bit exp_phase   [NUM_CH];
   int m_sample;
   bit m_audio;
   bit m_amp;

   bit obs_prev [NUM_CH];
   int rise_t   [NUM_CH];
   int fall_t   [NUM_CH];

   task automatic check_eq(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at edge %0d", tag, got, exp, n);
      end
   endtask

   function automatic int next_per(input int p, input int st, input bit up);
      if (up) return (p + st > PER_MAX) ? PER_MAX : p + st;
      return (p - st < MIN_PER) ? MIN_PER : p - st;
   endfunction

   task automatic model_reset();
      n        = 0;
      m_sample = 0;
      m_audio  = 0;
      m_amp    = 0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         m_trig_prev[ch] = 0;
         m_act[ch]       = 0;
         m_vol[ch]       = 0;
         m_ntog[ch]      = 0;
         exp_busy[ch]    = 0;
         exp_phase[ch]   = 0;
         obs_prev[ch]    = 0;
      end
   endtask

   task automatic model_load(input int ch);
      int p, t, len, st;
      bit up;
      len = int'(length[ch*LEN_W +: LEN_W]);
      p   = int'(start_per[ch*PER_W +: PER_W]);
      st  = int'(step[ch*STEP_W +: STEP_W]);
      up  = sweep_up[ch];
      if (p == 0) p = MIN_PER;
      $display("start ch=%0d edge=%0d per=%0d step=%0d up=%0d len=%0d vol=%0d",
               ch, n, p, st, up, len, int'(volume[ch*VOL_W +: VOL_W]));
      t = n;
      for (int k = 0; k < len; k++) begin
         t = t + p;
         m_tog[ch][k] = t;
         p = next_per(p, st, up);
      end
      m_ntog[ch]  = len;
      m_end[ch]   = t;
      m_start[ch] = n;
      m_act[ch]   = 1;
      m_vol[ch]   = int'(volume[ch*VOL_W +: VOL_W]);
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_edge();
      int lvl, c;
      bit any_busy, st;
      n++;
      lvl = 0;
      any_busy = 0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (exp_phase[ch]) lvl += m_vol[ch];
         if (exp_busy[ch]) any_busy = 1;
      end
      if (lvl > PWM_MAX) lvl = PWM_MAX;
      m_audio = ((n - 1) % FRAME) < m_sample;
      m_amp   = any_busy || (m_sample != 0);
      if ((n - 1) % FRAME == FRAME - 1) m_sample = mute ? 0 : lvl;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         st = trigger[ch] && !m_trig_prev[ch];
         m_trig_prev[ch] = trigger[ch];
         if (st && length[ch*LEN_W +: LEN_W] != '0) model_load(ch);
         exp_busy[ch] = m_act[ch] && (n < m_end[ch]);
         if (!exp_busy[ch]) m_act[ch] = 0;
         c = 0;
         for (int k = 0; k < m_ntog[ch]; k++) if (m_tog[ch][k] <= n) c++;
         exp_phase[ch] = exp_busy[ch] && c[0];
      end
   endtask

   task automatic tick(input string tag);
      @(posedge CLK100MHZ);
      #1;
      model_edge();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         check_eq($sformatf("%s_busy%0d", tag, ch), int'(busy[ch]), int'(exp_busy[ch]));
         if (busy[ch] && !obs_prev[ch]) rise_t[ch] = n;
         if (!busy[ch] && obs_prev[ch]) fall_t[ch] = n;
         obs_prev[ch] = busy[ch];
      end
      check_eq({tag, "_audio"}, int'(audio_out), int'(m_audio));
      check_eq({tag, "_amp"}, int'(amp_en), int'(m_amp));
   endtask

   task automatic set_voice(input int ch, input int per, input int st, input int up,
                            input int len, input int vol);
      start_per[ch*PER_W +: PER_W]  = PER_W'(per);
      step[ch*STEP_W +: STEP_W]     = STEP_W'(st);
      sweep_up[ch]                  = up[0];
      length[ch*LEN_W +: LEN_W]     = LEN_W'(len);
      volume[ch*VOL_W +: VOL_W]     = VOL_W'(vol);
   endtask

   task automatic fire(input logic [NUM_CH-1:0] mask, input string tag);
      trigger = '0;
      tick(tag);
      for (int ch = 0; ch < NUM_CH; ch++) if (mask[ch]) begin
         rise_t[ch] = -1;
         fall_t[ch] = -1;
      end
      trigger = mask;
      tick(tag);
      trigger = '0;
   endtask

   task automatic wait_idle(input int ch, input int budget, input string tag);
      int k;
      k = 0;
      while (busy[ch] && k < budget) begin
         tick(tag);
         k++;
      end
      check_eq({tag, "_idle"}, int'(busy[ch]), 0);
   endtask

   task automatic gap(input int cycles);
      repeat (cycles) tick("gap");
   endtask

   initial begin
      int hi;
      CPU_RESETN = 1'b0;
      trigger    = '0;
      start_per  = '0;
      step       = '0;
      sweep_up   = '0;
      length     = '0;
      volume     = '0;
      mute       = 1'b0;
      model_reset();
      repeat (3) @(posedge CLK100MHZ);
      #1;
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_audio", int'(audio_out), 0);
      check_eq("rst_amp", int'(amp_en), 0);
      #3 CPU_RESETN = 1'b1;

      // Basic tone: 4 half-cycles of 4 clocks each
      set_voice(0, 4, 0, 1, 4, 15);
      fire(2'b01, "tone");
      wait_idle(0, 100, "tone");
      check_eq("tone_len", fall_t[0] - rise_t[0], 16);
      gap(40);

      // Sweep down to the MIN_PER floor: 100+70+40+16+16+16
      set_voice(0, 100, 30, 0, 6, 10);
      fire(2'b01, "sweep");
      wait_idle(0, 1000, "sweep");
      check_eq("sweep_len", fall_t[0] - rise_t[0], 258);
      gap(40);

      // Retrigger 30 cycles in: full 10 half-cycles from the retrigger edge
      set_voice(0, 50, 0, 1, 10, 7);
      fire(2'b01, "retrig");
      repeat (28) tick("retrig");
      fire(2'b01, "retrig");
      check_eq("retrig_busy", int'(busy[0]), 1);
      wait_idle(0, 1000, "retrig");
      check_eq("retrig_len", fall_t[0] - m_start[0], 500);
      gap(40);

      // Two full-volume voices high together saturate the mixer
      set_voice(0, 200, 0, 1, 2, 15);
      set_voice(1, 200, 0, 1, 2, 15);
      fire(2'b11, "sat");
      repeat (240) tick("sat");
      hi = 0;
      for (int k = 0; k < FRAME; k++) begin
         tick("sat");
         hi += int'(audio_out);
      end
      check_eq("sat_duty", hi, FRAME - 1);
      mute = 1'b1;
      repeat (40) tick("mute");
      hi = 0;
      for (int k = 0; k < FRAME; k++) begin
         tick("mute");
         hi += int'(audio_out);
      end
      check_eq("mute_duty", hi, 0);
      mute = 1'b0;
      wait_idle(0, 1000, "sat");
      wait_idle(1, 1000, "sat");
      gap(40);

      // Upward sweep saturating at the period maximum: 900+1023+1023
      set_voice(1, 900, 200, 1, 3, 5);
      fire(2'b10, "satper");
      wait_idle(1, 4000, "satper");
      check_eq("satper_len", fall_t[1] - rise_t[1], 2946);
      gap(40);

      // Length zero triggers are ignored
      set_voice(0, 20, 0, 1, 0, 15);
      set_voice(1, 20, 0, 1, 0, 15);
      fire(2'b11, "len0");
      repeat (20) tick("len0");
      check_eq("len0_busy", int'(busy), 0);
      check_eq("len0_amp", int'(amp_en), 0);

      // Random triggers and configuration changes
      for (int it = 0; it < 250; it++) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            set_voice(ch,
                      ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40)),
                      int'($urandom_range(0, 25)), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 6)), int'($urandom_range(0, 15)));
         end
         trigger = NUM_CH'($urandom);
         mute    = ($urandom_range(0, 7) == 0);
         repeat ($urandom_range(1, 40)) tick("rnd");
      end
      mute = 1'b0;

      // Reset in the middle of an effect clears outputs without waiting for a clock
      set_voice(1, 30, 0, 1, 8, 9);
      fire(2'b10, "prerst");
      repeat (50) tick("prerst");
      check_eq("prerst_amp", int'(amp_en), 1);
      #2 CPU_RESETN = 1'b0;
      #1;
      check_eq("arst_busy", int'(busy), 0);
      check_eq("arst_audio", int'(audio_out), 0);
      check_eq("arst_amp", int'(amp_en), 0);
      trigger = '0;
      model_reset();
      repeat (2) @(posedge CLK100MHZ);
      #4 CPU_RESETN = 1'b1;
      repeat (30) tick("postrst");
      check_eq("postrst_busy", int'(busy), 0);
      check_eq("postrst_amp", int'(amp_en), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
